// File: rtl/store_buffer_pkg.sv
// Shared types, default widths and the byte-lane merge helper for the store buffer.
package store_buffer_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefSelWidth  = DefDataWidth / 8;
  localparam int unsigned DefFifoDepth = 4;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefDataWidth-1:0] wdata;
    logic [DefSelWidth-1:0]  sel_byte;
  } stb_entry_t;

  localparam int unsigned EntryWidth = $bits(stb_entry_t);

  typedef enum logic {
    StIdle,
    StWrite
  } stb_state_e;

  // New data wins on every enabled lane; enables accumulate.
  function automatic stb_entry_t merge_entry(stb_entry_t              old_e,
                                             logic [DefDataWidth-1:0] wdata,
                                             logic [DefSelWidth-1:0]  sel);
    stb_entry_t res;
    res = old_e;
    for (int unsigned i = 0; i < DefSelWidth; i++) begin
      if (sel[i]) res.wdata[8*i +: 8] = wdata[8*i +: 8];
    end
    res.sel_byte = old_e.sel_byte | sel;
    return res;
  endfunction

endpackage

// File: rtl/store_buffer_stb_fifo.sv
// In-order entry storage for the store buffer: circular pointers, occupancy count,
// and an in-place merge port that updates the youngest entry.
module stb_fifo
  import store_buffer_pkg::*;
#(
  parameter int unsigned Depth = DefFifoDepth
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic [EntryWidth-1:0]   push_entry_i,
  input  logic                    pop_i,
  input  logic                    merge_i,
  input  logic [DefDataWidth-1:0] merge_wdata_i,
  input  logic [DefSelWidth-1:0]  merge_sel_i,
  output logic [EntryWidth-1:0]   head_o,
  output logic [EntryWidth-1:0]   tail_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    single_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  stb_entry_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] tail_idx;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop, do_merge;

  assign full_o   = (count_q == CntW'(Depth));
  assign empty_o  = (count_q == '0);
  assign single_o = (count_q == CntW'(1));

  assign do_push  = push_i & ~full_o;
  assign do_pop   = pop_i & ~empty_o;
  assign do_merge = merge_i & ~empty_o & ~push_i;

  assign tail_idx = wr_ptr_q - PtrW'(1);
  assign head_o   = mem_q[rd_ptr_q];
  assign tail_o   = mem_q[tail_idx];

  // Depth is a power of two, so pointer wrap is plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= stb_entry_t'(push_entry_i);
      end else if (do_merge) begin
        mem_q[tail_idx] <= merge_entry(mem_q[tail_idx], merge_wdata_i, merge_sel_i);
      end
    end
  end

endmodule

// File: rtl/store_buffer_top.sv
// Write-back store buffer between the LSU data port and the dcache.
// Optional store coalescing into the youngest entry: define STB_COALESCE_EN.
module store_buffer_top
  import store_buffer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned BYTE_SEL_WIDTH = DefSelWidth,
  parameter int unsigned FIFO_DEPTH     = DefFifoDepth,
  parameter int unsigned BLEN           = DefFifoDepth
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     lsudbus2stb_addr,
  input  logic [DATA_WIDTH-1:0]     lsudbus2stb_wdata,
  input  logic [BYTE_SEL_WIDTH-1:0] lsudbus2stb_sel_byte,
  input  logic                      lsudbus2stb_w_en,
  input  logic                      lsudbus2stb_req,
  input  logic                      dmem_sel_i,
  output logic                      stb2dbuslsu_stall,
  output logic                      stb2dbuslsu_ack,
  output logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
  output logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
  output logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
  output logic                      stb2dcache_w_en,
  output logic                      stb2dcache_req,
  output logic                      stb2dcache_empty,
  output logic                      dmem_sel_o,
  input  logic                      dcache2stb_ack
);

  if (BLEN != FIFO_DEPTH) begin : gen_bad_blen
    $error("BLEN must equal FIFO_DEPTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  if (ADDR_WIDTH != DefAddrWidth || DATA_WIDTH != DefDataWidth ||
      BYTE_SEL_WIDTH != DefSelWidth) begin : gen_bad_width
    $error("entry widths must match store_buffer_pkg defaults");
  end

  stb_state_e state_q;
  logic       ack_q;
  stb_entry_t push_entry, head, tail;
  logic       full, empty, single;
  logic       store_req, load_req, pass_through;
  logic       merge_hit, push, merge, pop;

  assign store_req    = lsudbus2stb_req & dmem_sel_i & lsudbus2stb_w_en;
  assign load_req     = lsudbus2stb_req & dmem_sel_i & ~lsudbus2stb_w_en;
  // A load only reaches the dcache once every older store has drained.
  assign pass_through = load_req & empty & (state_q == StIdle);

`ifdef STB_COALESCE_EN
  // The head in WRITE is frozen on the bus; merging into it would corrupt the transfer.
  assign merge_hit = store_req & ~empty &
                     (tail.addr[ADDR_WIDTH-1:2] == lsudbus2stb_addr[ADDR_WIDTH-1:2]) &
                     ~((state_q == StWrite) & single);
`else
  logic unused_coalesce;
  assign unused_coalesce = ^{tail, single};
  assign merge_hit = 1'b0;
`endif

  assign push  = store_req & ~full & ~ack_q & ~merge_hit;
  assign merge = merge_hit & ~ack_q;
  assign pop   = (state_q == StWrite) & dcache2stb_ack;

  assign push_entry = '{addr:     lsudbus2stb_addr,
                        wdata:    lsudbus2stb_wdata,
                        sel_byte: lsudbus2stb_sel_byte};

  stb_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .push_i        (push),
    .push_entry_i  (push_entry),
    .pop_i         (pop),
    .merge_i       (merge),
    .merge_wdata_i (lsudbus2stb_wdata),
    .merge_sel_i   (lsudbus2stb_sel_byte),
    .head_o        (head),
    .tail_o        (tail),
    .full_o        (full),
    .empty_o       (empty),
    .single_o      (single)
  );

  // Leaving WRITE on the ack edge guarantees a req-low cycle between drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= push | merge;
      unique case (state_q)
        StIdle:  if (!empty && !pass_through) state_q <= StWrite;
        StWrite: if (dcache2stb_ack)          state_q <= StIdle;
        default:                              state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    stb2dcache_addr     = '0;
    stb2dcache_wdata    = '0;
    stb2dcache_sel_byte = '0;
    stb2dcache_w_en     = 1'b0;
    stb2dcache_req      = 1'b0;
    if (state_q == StWrite) begin
      stb2dcache_addr     = head.addr;
      stb2dcache_wdata    = head.wdata;
      stb2dcache_sel_byte = head.sel_byte;
      stb2dcache_w_en     = 1'b1;
      stb2dcache_req      = 1'b1;
    end else if (pass_through) begin
      stb2dcache_addr     = lsudbus2stb_addr;
      stb2dcache_sel_byte = lsudbus2stb_sel_byte;
      stb2dcache_req      = 1'b1;
    end
  end

  assign dmem_sel_o        = stb2dcache_req;
  assign stb2dcache_empty  = empty;
  assign stb2dbuslsu_ack   = ack_q | (pass_through & dcache2stb_ack);
  assign stb2dbuslsu_stall = (store_req & full & ~merge_hit) |
                             (load_req & ~(empty & (state_q == StIdle)));

endmodule

// File: tb/tb_store_buffer_top.sv
// Randomized bench for store_buffer_top against a queue-based model of buffered stores.
module tb_store_buffer_top;

  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lsudbus2stb_addr = '0;
  logic [31:0] lsudbus2stb_wdata = '0;
  logic [3:0]  lsudbus2stb_sel_byte = '0;
  logic        lsudbus2stb_w_en = 1'b0;
  logic        lsudbus2stb_req = 1'b0;
  logic        dmem_sel_i = 1'b0;
  logic        dcache2stb_ack = 1'b0;
  logic        stb2dbuslsu_stall, stb2dbuslsu_ack;
  logic [31:0] stb2dcache_addr, stb2dcache_wdata;
  logic [3:0]  stb2dcache_sel_byte;
  logic        stb2dcache_w_en, stb2dcache_req, stb2dcache_empty, dmem_sel_o;

  store_buffer_top dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .lsudbus2stb_addr     (lsudbus2stb_addr),
    .lsudbus2stb_wdata    (lsudbus2stb_wdata),
    .lsudbus2stb_sel_byte (lsudbus2stb_sel_byte),
    .lsudbus2stb_w_en     (lsudbus2stb_w_en),
    .lsudbus2stb_req      (lsudbus2stb_req),
    .dmem_sel_i           (dmem_sel_i),
    .stb2dbuslsu_stall    (stb2dbuslsu_stall),
    .stb2dbuslsu_ack      (stb2dbuslsu_ack),
    .stb2dcache_addr      (stb2dcache_addr),
    .stb2dcache_wdata     (stb2dcache_wdata),
    .stb2dcache_sel_byte  (stb2dcache_sel_byte),
    .stb2dcache_w_en      (stb2dcache_w_en),
    .stb2dcache_req       (stb2dcache_req),
    .stb2dcache_empty     (stb2dcache_empty),
    .dmem_sel_o           (dmem_sel_o),
    .dcache2stb_ack       (dcache2stb_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } ent_t;

  ent_t mq[$];      // stores accepted and not yet written to the dcache, oldest first
  int   n_checks = 0;
  int   n_fails  = 0;
  bit   ack_pend = 1'b0;
  bit   dc_on    = 1'b1;
  int   dc_lat   = 2;
  int   dc_wait  = 0;
  bit   acc, load_done;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check at the falling edge, model the dcache, then advance past the rising edge.
  task automatic step_cycle();
    bit   store_req, load_req, exp_empty, dc_ack_v, passing;
    ent_t e;
    @(negedge clk);
    store_req = lsudbus2stb_req & dmem_sel_i & lsudbus2stb_w_en;
    load_req  = lsudbus2stb_req & dmem_sel_i & ~lsudbus2stb_w_en;
    exp_empty = (mq.size() == 0);
    passing   = load_req & exp_empty;
    check_eq("empty", 64'(stb2dcache_empty), 64'(exp_empty));
    check_eq("stall", 64'(stb2dbuslsu_stall),
             64'((store_req & (mq.size() == Depth)) | (load_req & ~exp_empty)));
    dc_ack_v = 1'b0;
    if (passing) begin
      check_eq("load_req", 64'(stb2dcache_req), 64'd1);
      check_eq("load_wen", 64'(stb2dcache_w_en), 64'd0);
      check_eq("load_addr", 64'(stb2dcache_addr), 64'(lsudbus2stb_addr));
      check_eq("load_sel", 64'(stb2dcache_sel_byte), 64'(lsudbus2stb_sel_byte));
      dc_wait++;
      if (dc_on && dc_wait > dc_lat) dc_ack_v = 1'b1;
    end else if (exp_empty) begin
      check_eq("idle_req", 64'(stb2dcache_req), 64'd0);
      dc_wait = 0;
    end else if (stb2dcache_req) begin
      e = mq[0];
      check_eq("drain_wen", 64'(stb2dcache_w_en), 64'd1);
      check_eq("drain_dmem_sel", 64'(dmem_sel_o), 64'd1);
      check_eq("drain_addr", 64'(stb2dcache_addr), 64'(e.addr));
      check_eq("drain_data", 64'(stb2dcache_wdata), 64'(e.data));
      check_eq("drain_sel", 64'(stb2dcache_sel_byte), 64'(e.sel));
      dc_wait++;
      if (dc_on && dc_wait > dc_lat) dc_ack_v = 1'b1;
    end else begin
      dc_wait = 0;
    end
    dcache2stb_ack = dc_ack_v;
    #1;
    check_eq("lsu_ack", 64'(stb2dbuslsu_ack), 64'(ack_pend | (passing & dc_ack_v)));
    acc       = store_req & (mq.size() < Depth) & ~ack_pend;
    load_done = passing & dc_ack_v;
    if (dc_ack_v) dc_wait = 0;
    if (dc_ack_v && !passing) void'(mq.pop_front());
    if (acc) mq.push_back('{addr: lsudbus2stb_addr, data: lsudbus2stb_wdata,
                            sel: lsudbus2stb_sel_byte});
    ack_pend = acc;
    @(posedge clk);
    #1;
    dcache2stb_ack = 1'b0;
  endtask

  task automatic lsu_idle();
    lsudbus2stb_req  = 1'b0;
    lsudbus2stb_w_en = 1'b0;
    dmem_sel_i       = 1'b0;
  endtask

  task automatic lsu_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    lsudbus2stb_addr     = a;
    lsudbus2stb_wdata    = d;
    lsudbus2stb_sel_byte = s;
    lsudbus2stb_w_en     = 1'b1;
    lsudbus2stb_req      = 1'b1;
    dmem_sel_i           = 1'b1;
  endtask

  // Holds the store until accepted, keeps it up through the ack cycle, then drops it.
  task automatic finish_store();
    int n = 0;
    do begin
      step_cycle();
      n++;
    end while (!acc && n < 60);
    check_eq("store_accepted", 64'(acc), 64'd1);
    step_cycle();
    lsu_idle();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    lsu_store(a, d, s);
    finish_store();
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] s);
    int n = 0;
    lsudbus2stb_addr     = a;
    lsudbus2stb_sel_byte = s;
    lsudbus2stb_wdata    = '0;
    lsudbus2stb_w_en     = 1'b0;
    lsudbus2stb_req      = 1'b1;
    dmem_sel_i           = 1'b1;
    do begin
      step_cycle();
      n++;
    end while (!load_done && n < 100);
    check_eq("load_done", 64'(load_done), 64'd1);
    lsu_idle();
  endtask

  task automatic wait_empty();
    int n = 0;
    while (mq.size() != 0 && n < 300) begin
      step_cycle();
      n++;
    end
    check_eq("drain_done", 64'(mq.size()), 64'd0);
    repeat (2) step_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_eq("rst_empty", 64'(stb2dcache_empty), 64'd1);
    check_eq("rst_req", 64'(stb2dcache_req), 64'd0);
    check_eq("rst_wen", 64'(stb2dcache_w_en), 64'd0);
    check_eq("rst_ack", 64'(stb2dbuslsu_ack), 64'd0);
    check_eq("rst_stall", 64'(stb2dbuslsu_stall), 64'd0);
    check_eq("rst_dmem_sel", 64'(dmem_sel_o), 64'd0);
    check_eq("rst_addr", 64'(stb2dcache_addr), 64'd0);
    check_eq("rst_wdata", 64'(stb2dcache_wdata), 64'd0);
    check_eq("rst_sel", 64'(stb2dcache_sel_byte), 64'd0);
    #5 rst_n = 1'b1;
    repeat (3) step_cycle();

    // Single store, held across the ack cycle; dcache answers 3 cycles after req.
    dc_lat = 3;
    do_store(32'h10, 32'hDEAD_BEEF, 4'hF);
    wait_empty();

    // Requests not aimed at data memory are ignored.
    lsu_store(32'h20, 32'h1234_5678, 4'h3);
    dmem_sel_i = 1'b0;
    repeat (3) step_cycle();
    lsu_idle();

    // Random stores with random gaps; ten entries wrap the four-deep pointers.
    dc_lat = 2;
    for (int i = 0; i < 10; i++) begin
      do_store($urandom, $urandom, 4'($urandom_range(1, 15)));
      repeat ($urandom_range(0, 2)) step_cycle();
    end
    wait_empty();

    // Fill with the dcache silent, then a fifth store stalls until the first drain.
    dc_on = 1'b0;
    for (int i = 0; i < Depth; i++) do_store(32'h100 + 32'(4 * i), $urandom, 4'hF);
    lsu_store(32'h110, 32'hCAFE_F00D, 4'h5);
    repeat (4) step_cycle();
    dc_on  = 1'b1;
    dc_lat = 1;
    finish_store();
    wait_empty();

    // A load waits behind two buffered stores, then passes through.
    dc_lat = 2;
    do_store(32'h300, 32'hA5A5_0001, 4'hF);
    do_store(32'h304, 32'hA5A5_0002, 4'hC);
    do_load(32'h200, 4'hF);
    repeat (2) step_cycle();

    // Reset in the middle of a drain with three entries queued.
    dc_on = 1'b0;
    do_store(32'h400, $urandom, 4'hF);
    do_store(32'h404, $urandom, 4'hF);
    do_store(32'h408, $urandom, 4'hF);
    repeat (2) step_cycle();
    check_eq("pre_rst_req", 64'(stb2dcache_req), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", 64'(stb2dcache_req), 64'd0);
    check_eq("mid_rst_empty", 64'(stb2dcache_empty), 64'd1);
    check_eq("mid_rst_dmem_sel", 64'(dmem_sel_o), 64'd0);
    mq.delete();
    ack_pend = 1'b0;
    dc_wait  = 0;
    dc_on    = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) step_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
